// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - fetch/decode/execute controller wrapped around an external 8-bit ALU
// Owns pc, IR/IMMR, accumulator, C/Z flags and the register file; the ALU itself is combinational outside.
module alu_sequencer #(
  parameter int PC_W  = 8,
  parameter int NREGS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] pc,
  output logic            instr_req,
  input  logic            instr_valid,
  input  logic [7:0]      instr_i,
  output logic [2:0]      alu_code,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_r,
  output logic            alu_ci,
  input  logic [7:0]      alu_out,
  input  logic            alu_co,
  output logic [7:0]      acc,
  output logic            carry,
  output logic            zero,
  output logic            halted
);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_LD  = 3'd6;

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_LD  = 4'h7;
  localparam logic [3:0] OP_ST  = 4'h8;
  localparam logic [3:0] OP_ADC = 4'hA;
  localparam logic [3:0] OP_SBC = 4'hB;
  localparam logic [3:0] OP_LDI = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int RI_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_IMM,
    S_EXEC,
    S_HALT
  } state_t;

  state_t          state, next;
  logic [7:0]      ir;
  logic [7:0]      immr;
  logic [7:0]      regs [NREGS];
  logic [3:0]      op;
  logic [RI_W-1:0] rsel;
  logic            is_arith;
  logic            unused_bits;

  assign op          = ir[7:4];
  assign rsel        = RI_W'(32'(ir[2:0]) % NREGS);
  assign unused_bits = ir[3];
  assign is_arith    = (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) || (op == OP_SBC);
  assign alu_a       = acc;
  assign halted      = (state == S_HALT);

  always_comb begin
    next      = state;
    instr_req = 1'b0;
    alu_code  = ALU_LD;
    alu_ci    = 1'b0;
    alu_r     = regs[rsel];
    unique case (state)
      S_FETCH: begin
        instr_req = 1'b1;
        if (instr_valid) next = S_DECODE;
      end
      S_DECODE: begin
        unique case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
          OP_LD, OP_ST, OP_ADC, OP_SBC: next = S_EXEC;
          OP_LDI:                       next = S_IMM;
          OP_HLT:                       next = S_HALT;
          default:                      next = S_FETCH;
        endcase
      end
      S_IMM: begin
        instr_req = 1'b1;
        if (instr_valid) next = S_EXEC;
      end
      S_EXEC: begin
        next = S_FETCH;
        unique case (op)
          OP_ADD:  alu_code = ALU_ADD;
          OP_ADC: begin
            alu_code = ALU_ADD;
            alu_ci   = carry;
          end
          OP_SUB:  alu_code = ALU_SUB;
          OP_SBC: begin
            alu_code = ALU_SUB;
            alu_ci   = carry;
          end
          OP_AND:  alu_code = ALU_AND;
          OP_OR:   alu_code = ALU_OR;
          OP_XOR:  alu_code = ALU_XOR;
          OP_NOT:  alu_code = ALU_NOT;
          OP_LDI:  alu_r    = immr;
          default: alu_code = ALU_LD;
        endcase
      end
      S_HALT:  next = S_HALT;
      default: next = S_FETCH;
    endcase
    // Memory must never see a request while the controller is held in reset.
    instr_req = instr_req & rst_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      pc    <= '0;
      ir    <= 8'h00;
      immr  <= 8'h00;
      acc   <= 8'h00;
      carry <= 1'b0;
      zero  <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
    end else begin
      state <= next;
      if ((state == S_FETCH || state == S_IMM) && instr_valid) pc <= pc + PC_W'(1);
      if (state == S_FETCH && instr_valid) ir <= instr_i;
      if (state == S_IMM && instr_valid) immr <= instr_i;
      if (state == S_EXEC) begin
        if (op == OP_ST) begin
          regs[rsel] <= acc;
        end else begin
          acc  <= alu_out;
          zero <= (alu_out == 8'h00);
          if (is_arith) carry <= alu_co;
        end
      end
    end
  end

endmodule
